// File: rtl/k2red_unscale.sv
// Iterative post-scaler for K2-RED: R = A * 2^(2W) mod q (= A * k^-2 mod q),
// computed by 2W conditional modular doublings, STEPS per clock.
module k2red_unscale #(
  parameter int unsigned LOGQ  = 32,
  parameter int unsigned LOGQH = 15,
  parameter int unsigned STEPS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LOGQ-1:0]  A,
  input  logic [LOGQH-1:0] qH,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOGQ-1:0]  R,
  output logic             busy
);

  localparam int unsigned W     = LOGQ - LOGQH;
  localparam int unsigned TOTAL = 2 * W;
  localparam int unsigned CW    = $clog2(TOTAL + 1);

  if (STEPS == 0 || (TOTAL % STEPS) != 0) begin : g_steps_check
    $error("k2red_unscale: STEPS must divide 2*(LOGQ-LOGQH)");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [LOGQ-1:0] x_q, x_d, q_q, q_d, r_d, x_step;
  logic [LOGQ-1:0] q_in, a_red;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cnt_last;

  // q = qH * 2^W + 1; inputs in [q, 2q) are folded once at capture
  assign q_in  = {qH, W'(1)};
  assign a_red = (A >= q_in) ? A - q_in : A;

  assign cnt_last = ((CW+1)'(cnt_q) + (CW+1)'(STEPS)) == (CW+1)'(TOTAL);

  function automatic logic [LOGQ-1:0] mod_dbl(input logic [LOGQ-1:0] x,
                                               input logic [LOGQ-1:0] q);
    logic [LOGQ:0] y;
    y = {x, 1'b0};
    if (y >= {1'b0, q}) y = y - {1'b0, q};
    return y[LOGQ-1:0];
  endfunction

  always_comb begin
    x_step = x_q;
    for (int unsigned i = 0; i < STEPS; i++) x_step = mod_dbl(x_step, q_q);
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    r_d     = R;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          q_d     = q_in;
          x_d     = a_red;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        x_d   = x_step;
        cnt_d = cnt_q + CW'(STEPS);
        if (cnt_last) begin
          r_d     = x_step;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they track it exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      x_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      R         <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      R         <= r_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_k2red_unscale.sv
// Directed bench for k2red_unscale: small q=97 instances (STEPS=1,2) and a
// default-size instance checked against the k^2 identity round trip.
module tb_k2red_unscale;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // u1: LOGQ=8, LOGQH=3, STEPS=1
  logic       v1, or1, rdy1, ov1, busy1;
  logic [7:0] a1, r1;
  logic [2:0] qh1;
  // u2: LOGQ=8, LOGQH=3, STEPS=2
  logic       v2, or2, rdy2, ov2, busy2;
  logic [7:0] a2, r2;
  logic [2:0] qh2;
  // u3: defaults
  logic        v3, or3, rdy3, ov3, busy3;
  logic [31:0] a3, r3;
  logic [14:0] qh3;

  k2red_unscale #(.LOGQ(8), .LOGQH(3), .STEPS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .A(a1), .qH(qh1),
    .out_valid(ov1), .out_ready(or1), .R(r1), .busy(busy1));
  k2red_unscale #(.LOGQ(8), .LOGQH(3), .STEPS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2), .A(a2), .qH(qh2),
    .out_valid(ov2), .out_ready(or2), .R(r2), .busy(busy2));
  k2red_unscale u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(rdy3), .A(a3), .qH(qh3),
    .out_valid(ov3), .out_ready(or3), .R(r3), .busy(busy3));

  function automatic logic rdy_of(input int d);
    case (d)
      1: return rdy1;
      2: return rdy2;
      default: return rdy3;
    endcase
  endfunction

  function automatic logic ov_of(input int d);
    case (d)
      1: return ov1;
      2: return ov2;
      default: return ov3;
    endcase
  endfunction

  function automatic logic [31:0] r_of(input int d);
    case (d)
      1: return 32'(r1);
      2: return 32'(r2);
      default: return r3;
    endcase
  endfunction

  task automatic drive(input int d, input logic v, input logic [31:0] a, input logic [14:0] qh);
    case (d)
      1: begin v1 = v; a1 = a[7:0]; qh1 = qh[2:0]; end
      2: begin v2 = v; a2 = a[7:0]; qh2 = qh[2:0]; end
      default: begin v3 = v; a3 = a; qh3 = qh; end
    endcase
  endtask

  // One transaction with out_ready high; lat = edges from acceptance to out_valid
  task automatic xact(input int d, input logic [31:0] a, input logic [14:0] qh,
                      output logic [31:0] r, output int lat, output logic ok);
    int n;
    ok = 1'b1; lat = 0; r = '0;
    @(negedge clk);
    n = 0;
    while (!rdy_of(d) && n < 100) begin @(negedge clk); n++; end
    if (!rdy_of(d)) begin ok = 1'b0; return; end
    drive(d, 1'b1, a, qh);
    @(posedge clk); #1;
    drive(d, 1'b0, a, qh);
    n = 0;
    while (!ov_of(d) && n < 200) begin @(posedge clk); #1; n++; end
    if (!ov_of(d)) ok = 1'b0;
    r = r_of(d);
    lat = n;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    checks++;
    if (rdy1 !== 1'b0 || ov1 !== 1'b0 || busy1 !== 1'b0 || r1 !== 8'd0) begin
      failures++;
      $display("FAIL reset_values: rdy=%b ov=%b busy=%b R=%0d, want 0 0 0 0", rdy1, ov1, busy1, r1);
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    checks++;
    if (rdy1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_rdy: in_ready=%b right after release, want 0", rdy1);
    end
    @(posedge clk); #1;
    checks++;
    if (rdy1 !== 1'b1 || ov1 !== 1'b0 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: rdy=%b ov=%b busy=%b, want 1 0 0", rdy1, ov1, busy1);
    end
  endtask

  task automatic test_basic;
    logic [31:0] va[3], ve[3], r;
    int lat;
    logic ok;
    va[0] = 1;  ve[0] = 54;
    va[1] = 96; ve[1] = 43;
    va[2] = 0;  ve[2] = 0;
    for (int i = 0; i < 3; i++) begin
      xact(1, va[i], 15'd3, r, lat, ok);
      checks++;
      if (!ok || r !== ve[i]) begin
        failures++;
        $display("FAIL basic_R A=%0d: got %0d (ok=%b), want %0d", va[i], r, ok, ve[i]);
      end
      checks++;
      if (lat != 10) begin
        failures++;
        $display("FAIL basic_latency A=%0d: got %0d, want 10", va[i], lat);
      end
    end
  endtask

  task automatic test_capture_correction;
    logic [31:0] va[2], ve[2], r;
    int lat;
    logic ok;
    va[0] = 97;  ve[0] = 0;
    va[1] = 100; ve[1] = 65;
    for (int i = 0; i < 2; i++) begin
      xact(1, va[i], 15'd3, r, lat, ok);
      checks++;
      if (!ok || r !== ve[i]) begin
        failures++;
        $display("FAIL capture_R A=%0d: got %0d (ok=%b), want %0d", va[i], r, ok, ve[i]);
      end
    end
  endtask

  task automatic test_steps2;
    logic [31:0] r;
    int lat;
    logic ok;
    xact(2, 32'd1, 15'd3, r, lat, ok);
    checks++;
    if (!ok || r !== 32'd54 || lat != 5) begin
      failures++;
      $display("FAIL steps2: R=%0d lat=%0d (ok=%b), want R=54 lat=5", r, lat, ok);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] va[3], ve[3], rs;
    int acc_at[3];
    int cyc, sent, got;
    logic acc, hs;
    va[0] = 8'd1;  ve[0] = 8'd54;
    va[1] = 8'd96; ve[1] = 8'd43;
    va[2] = 8'd100; ve[2] = 8'd65;
    cyc = 0; sent = 0; got = 0;
    @(negedge clk);
    or2 = 1'b1; qh2 = 3'd3; v2 = 1'b1; a2 = va[0];
    while (got < 3 && cyc < 200) begin
      acc = v2 && rdy2;
      hs  = ov2 && or2;
      rs  = r2;
      @(posedge clk);
      cyc++;
      if (acc && sent < 3) begin acc_at[sent] = cyc; sent++; end
      if (hs) begin
        checks++;
        if (rs !== ve[got] || (cyc - acc_at[got]) != 6) begin
          failures++;
          $display("FAIL b2b_%0d: R=%0d span=%0d, want R=%0d span=6", got, rs, cyc - acc_at[got], ve[got]);
        end
        got++;
      end
      @(negedge clk);
      if (acc) begin
        if (sent < 3) a2 = va[sent];
        else v2 = 1'b0;
      end
    end
    v2 = 1'b0;
    checks++;
    if (got != 3) begin
      failures++;
      $display("FAIL b2b_timeout: got %0d results, want 3", got);
    end
  endtask

  task automatic test_backpressure;
    int n;
    or1 = 1'b0;
    @(negedge clk);
    v1 = 1'b1; a1 = 8'd1; qh1 = 3'd3;
    @(posedge clk); #1 v1 = 1'b0;
    n = 0;
    while (!ov1 && n < 50) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin v1 = 1'b1; a1 = 8'd96; end
      checks++;
      if (ov1 !== 1'b1 || r1 !== 8'd54 || rdy1 !== 1'b0 || busy1 !== 1'b1) begin
        failures++;
        $display("FAIL stall_%0d: ov=%b R=%0d rdy=%b busy=%b, want 1 54 0 1", i, ov1, r1, rdy1, busy1);
      end
    end
    @(negedge clk); or1 = 1'b1;
    @(negedge clk);
    checks++;
    if (rdy1 !== 1'b1 || ov1 !== 1'b0) begin
      failures++;
      $display("FAIL after_handshake: rdy=%b ov=%b, want 1 0", rdy1, ov1);
    end
    @(posedge clk); #1 v1 = 1'b0;
    n = 0;
    while (!ov1 && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (ov1 !== 1'b1 || r1 !== 8'd43 || n != 10) begin
      failures++;
      $display("FAIL stalled_input: ov=%b R=%0d lat=%0d, want 1 43 10", ov1, r1, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] r;
    int lat;
    logic ok, spurious;
    @(negedge clk);
    v1 = 1'b1; a1 = 8'd1; qh1 = 3'd3;
    @(posedge clk); #1 v1 = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (ov1 !== 1'b0 || busy1 !== 1'b0 || rdy1 !== 1'b0 || r1 !== 8'd0) begin
      failures++;
      $display("FAIL midrun_reset: ov=%b busy=%b rdy=%b R=%0d, want 0 0 0 0", ov1, busy1, rdy1, r1);
    end
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rdy1 !== 1'b1) begin
      failures++;
      $display("FAIL midrun_release_rdy: in_ready=%b, want 1", rdy1);
    end
    spurious = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (ov1 !== 1'b0 || busy1 !== 1'b0) spurious = 1'b1;
    end
    checks++;
    if (spurious) begin
      failures++;
      $display("FAIL midrun_spurious: out_valid/busy rose after reset, want both 0");
    end
    xact(1, 32'd100, 15'd3, r, lat, ok);
    checks++;
    if (!ok || r !== 32'd65 || lat != 10) begin
      failures++;
      $display("FAIL midrun_next: R=%0d lat=%0d (ok=%b), want 65 10", r, lat, ok);
    end
  endtask

  // A = k^2 * C mod q is what the K2-RED stage emits; unscaling must give C mod q
  task automatic test_roundtrip;
    longint unsigned q, k2, c, a, expv;
    logic [14:0] qh;
    logic [31:0] r;
    int lat;
    logic ok;
    for (int i = 0; i < 12; i++) begin
      qh = 15'($urandom) | 15'h4001;
      q  = (64'(qh) << 17) | 64'd1;
      k2 = 64'(qh) * 64'(qh);
      if (i == 0) c = 64'd0;
      else if (i == 1) c = (q - 64'd1) * (q - 64'd1);
      else c = {$urandom, $urandom} % (q * q);
      a    = (k2 * (c % q)) % q;
      expv = c % q;
      xact(3, 32'(a), qh, r, lat, ok);
      checks++;
      if (!ok || 64'(r) !== expv || lat != 34) begin
        failures++;
        $display("FAIL roundtrip_%0d q=%0d C=%0d: R=%0d lat=%0d (ok=%b), want R=%0d lat=34",
                 i, q, c, r, lat, ok, expv);
      end
    end
  endtask

  initial begin
    v1 = 1'b0; a1 = '0; qh1 = 3'd3; or1 = 1'b1;
    v2 = 1'b0; a2 = '0; qh2 = 3'd3; or2 = 1'b1;
    v3 = 1'b0; a3 = '0; qh3 = 15'h4001; or3 = 1'b1;
    test_reset();
    test_basic();
    test_capture_correction();
    test_steps2();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    test_roundtrip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
